// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Instruction-memory request/ack bus and fetch-to-decode
//               valid/ready bus of the InstructionFetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_fetch_unit_if;
    // Instruction memory channel
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // Decode channel
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    // Fetch unit side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready
    );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program-counter register and instruction-fetch sequencer.
//               Holds the PC, exports PC+4, fetches one instruction at a time
//               over a req/ack memory bus and hands it to decode over a
//               valid/ready bus. A redirect squashes in-flight/held fetches.
//               Optional macro IF_PERF_CNT_EN adds fetch_cnt / stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [31:0] next_pc,
    input  wire logic        redirect,
    output logic      [31:0] pc,
    output logic      [31:0] pc_plus4,
    pc_fetch_unit_if.master  bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic      [31:0] fetch_cnt,
    output logic      [31:0] stall_cnt
`endif
);

    // Instruction addresses are word aligned; low bits are forced to zero.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        if_valid_q,   if_valid_d;
    logic [31:0] if_instr_q,   if_instr_d;
    logic [31:0] if_pc_q,      if_pc_d;

    logic [31:0] next_pc_aligned;
    assign next_pc_aligned = next_pc & ~32'h3;

    // Next-state and datapath updates for the fetch sequencer.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    if (redirect) begin
                        // Returned word belongs to the squashed path.
                        pc_d = next_pc_aligned;
                    end else begin
                        if_valid_d = 1'b1;
                        if_instr_d = bus.imem_rdata;
                        if_pc_d    = pc_q;
                        state_d    = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Memory still owes an ack for the current address; keep
                    // presenting it until that ack arrives.
                    pc_d         = next_pc_aligned;
                    drain_addr_d = pc_q;
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pc_d = next_pc_aligned;
                end
                if (bus.imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect || bus.id_ready) begin
                    pc_d       = next_pc_aligned;
                    if_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC_ALIGNED;
            drain_addr_q <= 32'h0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 32'h0;
            if_pc_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
        end
    end

    // Outputs are registers or decoded from state only.
    assign pc            = pc_q;
    assign pc_plus4      = pc_q + 32'd4;
    assign bus.imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign bus.imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        accept;
    logic        stall;

    assign accept = (state_q == ST_HOLD) && bus.id_ready;
    assign stall  = ((state_q == ST_HOLD) && !bus.id_ready) ||
                    (((state_q == ST_REQ) || (state_q == ST_DRAIN)) && !bus.imem_ack);

    // Free-running event counters, wrapping naturally.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, accept};
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit: directed vector table
//               followed by randomized traffic against a transaction model.
//               Counter checks are included when IF_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          N_VEC  = 28;
    localparam int          N_RAND = 3000;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    pc_fetch_unit_if bus_if ();

    pc_fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .next_pc   (next_pc),
        .redirect  (redirect),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .bus       (bus_if)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic        rdy;
        logic        rdr;
        logic [31:0] npc;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic a, input logic y, input logic d,
                                input logic [31:0] np, input logic [31:0] rd,
                                input logic [31:0] ep, input logic eq, input logic [31:0] ea,
                                input logic ev, input logic [31:0] eip, input logic [31:0] ei);
        vec_t v;
        v.rst_n = r;  v.ack = a;  v.rdy = y;  v.rdr = d;  v.npc = np;  v.rdata = rd;
        v.e_pc = ep;  v.e_req = eq;  v.e_addr = ea;  v.e_valid = ev;
        v.e_ifpc = eip;  v.e_instr = ei;
        return v;
    endfunction

    // Instruction memory contents as a fixed function of the address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    vec_t vecs [N_VEC];

    // Transaction-level reference: expected PC, the pending fetch address,
    // whether that fetch was squashed, and the instruction held for decode.
    logic        m_idle, m_req, m_valid, m_stale;
    logic [31:0] m_pc, m_addr, m_ifpc, m_instr;
    logic [31:0] m_fetch, m_stall;

    task automatic model_reset();
        m_idle = 1'b1;  m_req = 1'b0;  m_valid = 1'b0;  m_stale = 1'b0;
        m_pc = RST_PC;  m_addr = 32'h0;  m_ifpc = 32'h0;  m_instr = 32'h0;
        m_fetch = 32'h0;  m_stall = 32'h0;
    endtask

    task automatic model_step(input logic ack, input logic rdy, input logic rdr,
                              input logic [31:0] npc);
        if (m_valid) begin
            if (rdy) m_fetch = m_fetch + 32'd1;
            else     m_stall = m_stall + 32'd1;
        end else if (m_req && !ack) begin
            m_stall = m_stall + 32'd1;
        end

        if (m_idle) begin
            m_idle = 1'b0;
            m_req  = 1'b1;
            m_addr = m_pc;
        end else if (m_valid) begin
            if (rdy || rdr) begin
                m_pc    = npc & ~32'h3;
                m_valid = 1'b0;
                m_req   = 1'b1;
                m_addr  = m_pc;
                m_stale = 1'b0;
            end
        end else if (m_req) begin
            if (ack) begin
                if (rdr) m_pc = npc & ~32'h3;
                if (m_stale || rdr) begin
                    m_addr  = m_pc;
                    m_stale = 1'b0;
                end else begin
                    m_valid = 1'b1;
                    m_req   = 1'b0;
                    m_ifpc  = m_addr;
                    m_instr = memword(m_addr);
                end
            end else if (rdr) begin
                m_pc    = npc & ~32'h3;
                m_stale = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic ack, input logic rdy, input logic rdr,
                         input logic [31:0] npc, input logic [31:0] rdata);
        bus_if.imem_ack   = ack;
        bus_if.id_ready   = rdy;
        redirect          = rdr;
        next_pc           = npc;
        bus_if.imem_rdata = rdata;
    endtask

    initial begin
        logic [31:0] exp_p4;
        logic        r_ack, r_rdy, r_rdr;
        logic [31:0] r_npc;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        vecs[0]  = mk(0,0,0,0, 32'h0,        32'h0,        32'h0000_0100,0,32'h0,        0,32'h0,        32'h0);
        vecs[1]  = mk(1,0,0,0, 32'h0,        32'h0,        32'h0000_0100,0,32'h0,        0,32'h0,        32'h0);
        vecs[2]  = mk(1,1,0,0, 32'h0,        32'hA000_0100,32'h0000_0100,1,32'h0000_0100,0,32'h0,        32'h0);
        vecs[3]  = mk(1,0,1,0, 32'h0000_0104,32'h0,        32'h0000_0100,0,32'h0,        1,32'h0000_0100,32'hA000_0100);
        vecs[4]  = mk(1,1,1,0, 32'h0,        32'hA000_0104,32'h0000_0104,1,32'h0000_0104,0,32'h0,        32'h0);
        vecs[5]  = mk(1,0,1,0, 32'h0000_0108,32'h0,        32'h0000_0104,0,32'h0,        1,32'h0000_0104,32'hA000_0104);
        vecs[6]  = mk(1,1,0,0, 32'h0,        32'hA000_0108,32'h0000_0108,1,32'h0000_0108,0,32'h0,        32'h0);
        for (int i = 7; i <= 11; i++)
            vecs[i] = mk(1,0,0,0, 32'h0000_010C,32'h0,     32'h0000_0108,0,32'h0,        1,32'h0000_0108,32'hA000_0108);
        vecs[12] = mk(1,0,1,0, 32'h0000_010C,32'h0,        32'h0000_0108,0,32'h0,        1,32'h0000_0108,32'hA000_0108);
        vecs[13] = mk(1,0,0,1, 32'h0000_2000,32'h0,        32'h0000_010C,1,32'h0000_010C,0,32'h0,        32'h0);
        vecs[14] = mk(1,0,0,0, 32'h0,        32'h0,        32'h0000_2000,1,32'h0000_010C,0,32'h0,        32'h0);
        vecs[15] = mk(1,0,0,0, 32'h0,        32'h0,        32'h0000_2000,1,32'h0000_010C,0,32'h0,        32'h0);
        vecs[16] = mk(1,1,0,0, 32'h0,        32'hDEAD_BEEF,32'h0000_2000,1,32'h0000_010C,0,32'h0,        32'h0);
        vecs[17] = mk(1,1,0,0, 32'h0,        32'hB000_2000,32'h0000_2000,1,32'h0000_2000,0,32'h0,        32'h0);
        vecs[18] = mk(1,0,1,1, 32'h0000_3000,32'h0,        32'h0000_2000,0,32'h0,        1,32'h0000_2000,32'hB000_2000);
        vecs[19] = mk(1,0,0,0, 32'h0,        32'h0,        32'h0000_3000,1,32'h0000_3000,0,32'h0,        32'h0);
        vecs[20] = mk(1,1,0,1, 32'h0000_4003,32'hC000_3000,32'h0000_3000,1,32'h0000_3000,0,32'h0,        32'h0);
        vecs[21] = mk(1,1,0,0, 32'h0,        32'hD000_4000,32'h0000_4000,1,32'h0000_4000,0,32'h0,        32'h0);
        vecs[22] = mk(1,0,0,1, 32'h0000_5000,32'h0,        32'h0000_4000,0,32'h0,        1,32'h0000_4000,32'hD000_4000);
        vecs[23] = mk(1,1,0,0, 32'h0,        32'hE000_5000,32'h0000_5000,1,32'h0000_5000,0,32'h0,        32'h0);
        vecs[24] = mk(1,0,1,0, 32'hFFFF_FFFC,32'h0,        32'h0000_5000,0,32'h0,        1,32'h0000_5000,32'hE000_5000);
        vecs[25] = mk(1,1,0,0, 32'h0,        32'hF000_0000,32'hFFFF_FFFC,1,32'hFFFF_FFFC,0,32'h0,        32'h0);
        vecs[26] = mk(1,0,1,0, 32'h0,        32'h0,        32'hFFFF_FFFC,0,32'h0,        1,32'hFFFF_FFFC,32'hF000_0000);
        vecs[27] = mk(1,0,0,0, 32'h0,        32'h0,        32'h0000_0000,1,32'h0000_0000,0,32'h0,        32'h0);

        // Directed table: each row checks current outputs, then applies inputs.
        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clk);
            exp_p4 = vecs[i].e_pc + 32'd4;
            chk($sformatf("vec%0d pc", i),       pc,                     vecs[i].e_pc);
            chk($sformatf("vec%0d pc_plus4", i), pc_plus4,               exp_p4);
            chk($sformatf("vec%0d imem_req", i), {31'd0, bus_if.imem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("vec%0d if_valid", i), {31'd0, bus_if.if_valid}, {31'd0, vecs[i].e_valid});
            if (vecs[i].e_req)
                chk($sformatf("vec%0d imem_addr", i), bus_if.imem_addr, vecs[i].e_addr);
            if (vecs[i].e_valid || i < 2) begin
                chk($sformatf("vec%0d if_pc", i),    bus_if.if_pc,    vecs[i].e_ifpc);
                chk($sformatf("vec%0d if_instr", i), bus_if.if_instr, vecs[i].e_instr);
            end
`ifdef IF_PERF_CNT_EN
            if (i == 27) begin
                chk("vec27 fetch_cnt", fetch_cnt, 32'd6);
                chk("vec27 stall_cnt", stall_cnt, 32'd10);
            end
`endif
            rst_n = vecs[i].rst_n;
            drive(vecs[i].ack, vecs[i].rdy, vecs[i].rdr, vecs[i].npc, vecs[i].rdata);
        end

        // Reset asserted mid-request must clear outputs without a clock edge.
        @(posedge clk);
        #2;
        chk("midreq pre imem_req", {31'd0, bus_if.imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreq imem_req", {31'd0, bus_if.imem_req}, 32'd0);
        chk("midreq pc",       pc,                       RST_PC);
        chk("midreq pc_plus4", pc_plus4,                 RST_PC + 32'd4);
        chk("midreq if_valid", {31'd0, bus_if.if_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("midreq fetch_cnt", fetch_cnt, 32'd0);
        chk("midreq stall_cnt", stall_cnt, 32'd0);
`endif

        // Randomized traffic against the reference model.
        model_reset();
        for (int c = 0; c < N_RAND; c++) begin
            @(negedge clk);
            if (c == 0) rst_n = 1'b1;
            chk("rnd pc",       pc,                        m_pc);
            chk("rnd pc_plus4", pc_plus4,                  m_pc + 32'd4);
            chk("rnd imem_req", {31'd0, bus_if.imem_req},  {31'd0, m_req});
            chk("rnd if_valid", {31'd0, bus_if.if_valid},  {31'd0, m_valid});
            if (m_req)
                chk("rnd imem_addr", bus_if.imem_addr, m_addr);
            if (m_valid) begin
                chk("rnd if_pc",    bus_if.if_pc,    m_ifpc);
                chk("rnd if_instr", bus_if.if_instr, m_instr);
            end
`ifdef IF_PERF_CNT_EN
            chk("rnd fetch_cnt", fetch_cnt, m_fetch);
            chk("rnd stall_cnt", stall_cnt, m_stall);
`endif
            r_ack = m_req && ($urandom_range(0, 99) < 50);
            r_rdy = ($urandom_range(0, 99) < 60);
            r_rdr = (m_req || m_valid) && ($urandom_range(0, 99) < 15);
            if (r_rdr || $urandom_range(0, 99) < 20) r_npc = $urandom;
            else                                     r_npc = m_pc + 32'd4;
            drive(r_ack, r_rdy, r_rdr, r_npc, r_ack ? memword(m_addr) : $urandom);
            model_step(r_ack, r_rdy, r_rdr, r_npc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer of the InstructionFetch stage. Holds the architectural PC, exports PC+4 to the PC multiplexer, loads the multiplexer's selected output (`next_pc`), runs a req/ack handshake with instruction memory, and presents one fetched instruction at a time to the decode stage with a valid/ready handshake. A branch/jump redirect discards any in-flight or held instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `next_pc`  in  32  selected next PC from the PC multiplexer; bits [1:0] ignored (treated as 0).
- `redirect`  in  1  next PC is non-sequential; squash current fetch.
- `pc`  out  32  current PC register.
- `pc_plus4`  out  32  `pc + 4`, combinational, mod 2^32.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `pc` while requesting.
- `imem_ack`  in  1  memory returns data this cycle; honoured only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a valid instruction.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  32  address of `if_instr`.
- `id_ready`  in  1  decode accepts instruction this cycle.

## Operation
- States: IDLE, REQ, HOLD, DRAIN.
- Reset (async): `pc`=RESET_PC, state IDLE, `imem_req`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0.
- IDLE: one cycle, no request; -> REQ.
- REQ: `imem_req`=1, `imem_addr`=`pc`, both stable until ack.
  - `imem_ack`=1, no `redirect`: register `if_instr`=`imem_rdata`, `if_pc`=`pc`, `if_valid`=1 -> HOLD.
  - `redirect`=1 with `imem_ack`=1: data dropped, `pc`<=`next_pc` -> REQ.
  - `redirect`=1 without ack: `pc`<=`next_pc` -> DRAIN (the old request is still owed an ack).
- DRAIN: `imem_req`=1, `imem_addr` = old address (held in internal register); on ack drop data -> REQ (new `pc`). Further `redirect` in DRAIN: `pc`<=`next_pc`, stay DRAIN.
- HOLD: `if_valid`=1, `imem_req`=0.
  - `id_ready`=1: `pc`<=`next_pc`, `if_valid`<=0 -> REQ.
  - `redirect`=1 (with or without `id_ready`): `pc`<=`next_pc`, `if_valid`<=0 -> REQ. Redirect wins; instruction counts as accepted only if `id_ready`=1.
  - neither: hold all outputs stable.
- `pc` changes only on the transitions above; `pc_plus4` always tracks `pc`.

## Timing
- Earliest ack in the same cycle as `imem_req` rising; `if_valid` rises the following edge.
- Sequential best case: 2 cycles/instruction (REQ with ack, HOLD with `id_ready`).
- First request asserted in cycle 2 after `rst_n` release (IDLE occupies cycle 1).
- `if_valid`, `if_instr`, `if_pc`, `imem_req`, `imem_addr` registered / state-decoded, no combinational path from `id_ready` or `imem_ack`.
- `rst_n` asserted mid-request: outstanding request abandoned, outputs to reset values immediately.

## Configuration
- `IF_PERF_CNT_EN` defined: adds outputs `fetch_cnt` (32, count of instructions accepted by decode) and `stall_cnt` (32, cycles in HOLD with `id_ready`=0 or in REQ/DRAIN without ack); both reset to 0, wrap mod 2^32, not affected by `redirect`.
- Not defined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset: `rst_n`=0 with RESET_PC=32'h0000_0100 -> `pc`=0x100, `pc_plus4`=0x104, `imem_req`=0, `if_valid`=0; after release, `imem_req`=1 in cycle 2 with `imem_addr`=0x100.
- Sequential fetch, immediate ack, `id_ready`=1, `next_pc`=`pc_plus4` -> `if_pc` sequence 0x100,0x104,0x108, one valid every 2 cycles, `if_instr` matches memory words.
- Decode stall: `id_ready`=0 for 5 cycles in HOLD -> `if_valid`, `if_instr`, `if_pc`, `pc` stable, `imem_req`=0; then `id_ready`=1 -> next request at 0x104.
- Redirect during outstanding request (ack delayed 3 cycles), `next_pc`=0x2000 -> `imem_addr` stays old value until ack, that data never appears on `if_instr`, next request at 0x2000.
- Redirect in HOLD with `id_ready`=1 same cycle -> `if_valid` drops next cycle, `pc`=`next_pc`, no duplicate instruction.
- `IF_PERF_CNT_EN`: 3 accepted instructions with 4 stall cycles -> `fetch_cnt`=3, `stall_cnt`=4; `pc` wrap 0xFFFF_FFFC -> `pc_plus4`=0.
